// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM states,
// ALU opcode encodings and requester tags.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational shared ALU: eight opcodes with carry, signed overflow
// and zero flags. Shift amounts use the full b operand.
module ALU
    import alu_arb_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int CTRL_WIDTH = 3
) (
    input  logic [CTRL_WIDTH-1:0] ctrl,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    output logic [WIDTH-1:0]      result,
    output logic                  carry,
    output logic                  overflow,
    output logic                  zero
);

    logic [WIDTH:0]        sum;
    logic [WIDTH:0]        diff;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic signed [WIDTH-1:0] r_s;

    // Subtraction as a + ~b + 1 so the carry-out reads as "no borrow".
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    assign a_s = $signed(a);
    assign b_s = $signed(b);
    assign r_s = $signed(result);

    always_comb begin
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (ctrl)
            ALU_ADD: begin
                result   = sum[WIDTH-1:0];
                carry    = sum[WIDTH];
                overflow = ((a_s < 0) == (b_s < 0)) && ((r_s < 0) != (a_s < 0));
            end
            ALU_SUB: begin
                result   = diff[WIDTH-1:0];
                carry    = diff[WIDTH];
                overflow = ((a_s < 0) != (b_s < 0)) && ((r_s < 0) != (a_s < 0));
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, (a < b)};
            // Shifting by the full b yields zero once b reaches WIDTH.
            ALU_SLL: result = a << b;
            ALU_SRL: result = a >> b;
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that time-shares one ALU between two requesters and
// returns tagged results over a valid/ready channel. Optional grant counters
// are built when ALU_ARB_STATS_EN is defined.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int CTRL_WIDTH = 3
`ifdef ALU_ARB_STATS_EN
    ,
    parameter int CNT_WIDTH  = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [CTRL_WIDTH-1:0] req0_ctrl,
    input  logic [WIDTH-1:0]      req0_a,
    input  logic [WIDTH-1:0]      req0_b,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [CTRL_WIDTH-1:0] req1_ctrl,
    input  logic [WIDTH-1:0]      req1_a,
    input  logic [WIDTH-1:0]      req1_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  rsp_carry,
    output logic                  rsp_overflow,
`ifdef ALU_ARB_STATS_EN
    output logic [CNT_WIDTH-1:0]  grant_cnt0,
    output logic [CNT_WIDTH-1:0]  grant_cnt1,
`endif
    output logic                  rsp_zero
);

    arb_state_t state;
    logic       prio;
    logic       any_req;
    logic       gnt_id;
    logic       accept;

    logic [CTRL_WIDTH-1:0] op_ctrl_p0;
    logic [WIDTH-1:0]      op_a_p0;
    logic [WIDTH-1:0]      op_b_p0;
    logic                  op_id_p0;

    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             alu_ovf;
    logic             alu_zero;

    logic             vld_p1;
    logic             id_p1;
    logic [WIDTH-1:0] res_p1;
    logic             carry_p1;
    logic             ovf_p1;
    logic             zero_p1;

    // Grant is combinational from the valids and registered state only, so
    // rsp_ready never reaches the request-side ready signals.
    always_comb begin
        any_req    = req0_valid | req1_valid;
        gnt_id     = (req0_valid && req1_valid) ? prio
                   : (req1_valid ? REQ_ID1 : REQ_ID0);
        accept     = (state == IDLE) && any_req && !rst;
        req0_ready = accept && (gnt_id == REQ_ID0);
        req1_ready = accept && (gnt_id == REQ_ID1);
    end

    // Stage p0: winning operation registered on the request handshake
    always_ff @(posedge clk) begin
        if (accept) begin
            op_ctrl_p0 <= (gnt_id == REQ_ID1) ? req1_ctrl : req0_ctrl;
            op_a_p0    <= (gnt_id == REQ_ID1) ? req1_a    : req0_a;
            op_b_p0    <= (gnt_id == REQ_ID1) ? req1_b    : req0_b;
            op_id_p0   <= gnt_id;
        end
    end

    ALU #(
        .WIDTH      (WIDTH),
        .CTRL_WIDTH (CTRL_WIDTH)
    ) u_alu (
        .ctrl     (op_ctrl_p0),
        .a        (op_a_p0),
        .b        (op_b_p0),
        .result   (alu_result),
        .carry    (alu_carry),
        .overflow (alu_ovf),
        .zero     (alu_zero)
    );

    // Stage p1: ALU result captured at the end of EXEC and held through RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            prio     <= REQ_ID0;
            vld_p1   <= 1'b0;
            id_p1    <= 1'b0;
            res_p1   <= '0;
            carry_p1 <= 1'b0;
            ovf_p1   <= 1'b0;
            zero_p1  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        prio  <= ~gnt_id;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    res_p1   <= alu_result;
                    carry_p1 <= alu_carry;
                    ovf_p1   <= alu_ovf;
                    zero_p1  <= alu_zero;
                    id_p1    <= op_id_p0;
                    vld_p1   <= 1'b1;
                    state    <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        vld_p1 <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp_valid    = vld_p1;
    assign rsp_id       = id_p1;
    assign rsp_result   = res_p1;
    assign rsp_carry    = carry_p1;
    assign rsp_overflow = ovf_p1;
    assign rsp_zero     = zero_p1;

`ifdef ALU_ARB_STATS_EN
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (req0_ready) grant_cnt0 <= sat_inc(grant_cnt0);
            if (req1_ready) grant_cnt1 <= sat_inc(grant_cnt1);
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: expected responses are modelled at each
// request handshake and compared whenever the response channel is valid.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_ctrl, req1_ctrl;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_carry, rsp_overflow, rsp_zero;
`ifdef ALU_ARB_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1;
`endif

    alu_arbiter #(.WIDTH(32), .CTRL_WIDTH(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_ctrl    (req0_ctrl),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_ctrl    (req1_ctrl),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_carry    (rsp_carry),
        .rsp_overflow (rsp_overflow),
`ifdef ALU_ARB_STATS_EN
        .grant_cnt0   (grant_cnt0),
        .grant_cnt1   (grant_cnt1),
`endif
        .rsp_zero     (rsp_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [31:0] res;
        logic        c;
        logic        o;
        logic        z;
        int          acc;
        bit          seen;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    logic mprio = 1'b0;
    logic egid;
    exp_t e;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic fail_timeout(input string tag);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out waiting for DUT", tag);
    endtask

    function automatic exp_t alu_model(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b);
        exp_t   r;
        longint sa, sb_v, s;
        sa   = longint'($signed(a));
        sb_v = longint'($signed(b));
        r.res = '0; r.c = 1'b0; r.o = 1'b0; r.id = 1'b0; r.acc = 0; r.seen = 0;
        case (ctrl)
            3'b000: begin
                r.res = a + b;
                r.c   = ({32'b0, a} + {32'b0, b}) > 64'hFFFF_FFFF;
                s     = sa + sb_v;
                r.o   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'b001: begin
                r.res = a - b;
                r.c   = (a >= b);
                s     = sa - sb_v;
                r.o   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'b010: r.res = a & b;
            3'b011: r.res = a | b;
            3'b100: r.res = a ^ b;
            3'b101: r.res = (a < b) ? 32'd1 : 32'd0;
            3'b110: r.res = (b >= 32) ? 32'd0 : (a << b[4:0]);
            default: r.res = (b >= 32) ? 32'd0 : (a >> b[4:0]);
        endcase
        r.z = (r.res == 32'd0);
        return r;
    endfunction

    // Monitor: model each handshake, compare every valid response cycle.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            sb.delete();
            mprio = 1'b0;
        end else begin
            if (req0_ready || req1_ready) begin
                egid = (req0_valid && req1_valid) ? mprio : req1_valid;
                check_eq("grant", req1_ready, egid);
                check_eq("one_ready", req0_ready & req1_ready, 0);
                e = egid ? alu_model(req1_ctrl, req1_a, req1_b)
                         : alu_model(req0_ctrl, req0_a, req0_b);
                e.id  = egid;
                e.acc = cyc;
                sb.push_back(e);
                mprio = ~egid;
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    fail_timeout("rsp_spurious");
                end else begin
                    if (!sb[0].seen) begin
                        check_eq("latency", cyc - sb[0].acc, 2);
                        sb[0].seen = 1;
                    end
                    check_eq("rsp_id", rsp_id, sb[0].id);
                    check_eq("rsp_result", rsp_result, sb[0].res);
                    check_eq("rsp_flags", {rsp_carry, rsp_overflow, rsp_zero},
                             {sb[0].c, sb[0].o, sb[0].z});
                    if (rsp_ready) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic drive_op(input bit id, input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_ctrl = ctrl; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_ctrl = ctrl; req1_a = a; req1_b = b;
        end
        forever begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) break;
            if (++n > 60) begin
                fail_timeout(id ? "req1_accept" : "req0_accept");
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || rsp_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail_timeout("drain");
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_ctrl = ALU_ADD; req0_a = 32'h7FFF_FFFF; req0_b = 32'd1;
        req1_valid = 1'b1; req1_ctrl = ALU_XOR; req1_a = 32'hF0F0_1234; req1_b = 32'h0FF0_4321;

        // Reset held with both requesters pending: everything quiet.
        repeat (2) begin
            @(negedge clk);
            check_eq("rst_outs", {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result,
                                  rsp_carry, rsp_overflow, rsp_zero}, 0);
        end
        @(posedge clk); #1 rst = 1'b0;

        // First simultaneous request: requester 0 wins, overflowing ADD.
        fork
            begin drive_op(0, ALU_ADD, 32'h7FFF_FFFF, 32'd1); req0_valid = 1'b0; end
            begin drive_op(1, ALU_XOR, 32'hF0F0_1234, 32'h0FF0_4321); req1_valid = 1'b0; end
        join
        wait_drain();

        // Both requesters saturated: grants alternate, neither starves.
        fork
            begin
                for (int i = 0; i < 4; i++)
                    drive_op(0, 3'(i * 2), $urandom, (i == 3) ? $urandom_range(0, 40) : $urandom);
                req0_valid = 1'b0;
            end
            begin
                for (int j = 0; j < 4; j++)
                    drive_op(1, 3'(j * 2 + 1), $urandom, (j == 3) ? $urandom_range(0, 40) : $urandom);
                req1_valid = 1'b0;
            end
        join
        wait_drain();

        // Response stall: outputs held, no new grant until the handshake.
        rsp_ready = 1'b0;
        drive_op(1, ALU_SUB, 32'd5, 32'd5);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_ctrl = ALU_ADD; req0_a = 32'd2; req0_b = 32'd3;
        @(negedge clk);
        check_eq("stall_rdy0_exec", req0_ready, 0);
        repeat (3) begin
            @(negedge clk);
            check_eq("stall_vld", rsp_valid, 1);
            check_eq("stall_rdy0", req0_ready, 0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("hs_rdy0", req0_ready, 0);
        @(negedge clk);
        check_eq("rsp_done", rsp_valid, 0);
        check_eq("regrant", req0_ready, 1);
        @(posedge clk); #1 req0_valid = 1'b0;
        wait_drain();

        // Shift boundaries and unsigned compare, plus a borrowing SUB.
        drive_op(0, ALU_SLL, 32'd1, 32'd31);
        drive_op(0, ALU_SLL, 32'd1, 32'd32);
        drive_op(0, ALU_SLT, 32'd1, 32'hFFFF_FFFF);
        drive_op(0, ALU_SUB, 32'd3, 32'd5);
        drive_op(0, ALU_SRL, 32'h8000_0000, 32'd31);
        req0_valid = 1'b0;
        wait_drain();

        // Reset while EXEC: operation dropped, next request served normally.
        drive_op(0, ALU_ADD, 32'd1, 32'd2);
        req0_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_eq("rst_drop_vld", rsp_valid, 0);
        end
        @(posedge clk); #1;
        drive_op(0, ALU_OR, 32'h0000_00F0, 32'h0000_000F);
        req0_valid = 1'b0;
        wait_drain();

`ifdef ALU_ARB_STATS_EN
        rst = 1'b1;
        @(negedge clk);
        check_eq("cnt_rst_a", {grant_cnt0, grant_cnt1}, 0);
        @(posedge clk); #1 rst = 1'b0;
        fork
            begin
                repeat (3) drive_op(0, ALU_AND, $urandom, $urandom);
                req0_valid = 1'b0;
            end
            begin
                repeat (2) drive_op(1, ALU_OR, $urandom, $urandom);
                req1_valid = 1'b0;
            end
        join
        wait_drain();
        check_eq("grant_cnt0", grant_cnt0, 3);
        check_eq("grant_cnt1", grant_cnt1, 2);
        rst = 1'b1;
        @(negedge clk);
        check_eq("cnt_rst_b", {grant_cnt0, grant_cnt1}, 0);
        @(posedge clk); #1 rst = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
